buff_responder: RTL

BUFF_RESPONDER -- requirements
Module: buff_responder

---
 rtl/buff_responder.sv | 96 +++++++++
 1 files changed

// File: rtl/buff_responder.sv
// Phase-driven buffer responder. A sequencer drives the phase on `state`:
// the fill phases (IN, BUFF) accept words into a circular buffer, the drain
// phase (OUT) hands them back in order. When the buffer becomes full in a fill
// phase, or empty in the drain phase, `changes` pulses once to ask the
// sequencer to advance. Further requests are held off until the phase
// actually moves. The reserved phase freezes traffic and raises a sticky error.
module buff_responder #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [1:0]                 state,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  input  logic                       out_ready,
  output logic                       changes,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    PH_IN   = 2'b00,
    PH_BUFF = 2'b01,
    PH_OUT  = 2'b10,
    PH_RSV  = 2'b11
  } phase_t;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr, rptr;
  logic [CW-1:0]     cnt;
  logic              wait_ack;
  logic [1:0]        req_state;

  logic fill, drain, push, pop, full_evt, empty_evt;

  // Phase decode and handshake qualification; everything is gated by reset so
  // no handshake is offered while the block is held in reset.
  always_comb begin
    fill      = reset && ((phase_t'(state) == PH_IN) || (phase_t'(state) == PH_BUFF));
    drain     = reset && (phase_t'(state) == PH_OUT);
    in_ready  = fill  && (cnt < CW'(DEPTH)) && !wait_ack;
    out_valid = drain && (cnt != '0) && !wait_ack;
    push      = in_valid  && in_ready;
    pop       = out_valid && out_ready;
    // Phase-complete conditions; wait_ack blocks re-requesting while the
    // sequencer has not yet moved to the new phase.
    full_evt  = fill  && (cnt == CW'(DEPTH)) && !wait_ack;
    empty_evt = drain && (cnt == '0) && !wait_ack;
  end

  assign out_data = mem[rptr];
  assign count    = cnt;

  // Buffer storage; contents survive reset, only the pointers are cleared.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= in_data;
  end

  // Pointers, occupancy, advance request handshake and sticky error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr      <= '0;
      rptr      <= '0;
      cnt       <= '0;
      changes   <= 1'b0;
      wait_ack  <= 1'b0;
      req_state <= 2'b00;
      err       <= 1'b0;
    end else begin
      // Pointers wrap naturally since DEPTH is a power of two.
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      // Push and pop live in exclusive phases, so at most one applies.
      if (push)     cnt <= cnt + CW'(1);
      else if (pop) cnt <= cnt - CW'(1);

      changes <= full_evt || empty_evt;
      if (full_evt || empty_evt) begin
        wait_ack  <= 1'b1;
        req_state <= state;
      end else if (wait_ack && (state != req_state)) begin
        wait_ack  <= 1'b0;
      end

      if (phase_t'(state) == PH_RSV) err <= 1'b1;
    end
  end

endmodule
